uop_serializer: RTL
===================

// Module: uop_serializer
// PURPOSE
// - Sits between the CVA6 commit ports and the fsm trace-packet builder.
// - Collects up to NR_COMMIT_PORTS retired uop entries per cycle and buffers them in program order.
// - Feeds the fsm one entry per cycle, so multi-commit cycles are traced without loss or reordering.
// - Flags, rather than silently hides, any commit it had to drop.
// PARAMETERS
// - NR_COMMIT_PORTS  2  commit ports sampled per cycle; port 0 is oldest.
// - DEPTH            8  buffer entries; power of two, >= NR_COMMIT_PORTS.
// PORTS
// - clk_i           in   1                        clock; all logic on posedge.
// - rst_i           in   1                        asynchronous, active-high reset.
// - uop_entry_i     in   NR_COMMIT_PORTS x uop_entry_s   commit-port entries; per-entry .valid.
// - in_ready_o      out  1                        buffer can absorb a full commit group this cycle.
// - flush_i         in   1                        synchronous discard of all buffered entries.
// - uop_entry_o     out  uop_entry_s              head entry to fsm; .valid = buffer non-empty.
// - out_ready_i     in   1                        consumer takes head this cycle (tie 1 for fsm).
// - occupancy_o     out  $clog2(DEPTH+1)          entries currently buffered.
// - overflow_o      out  1                        sticky: a commit group was dropped.
// - drop_cnt_o      out  16                       dropped valid entries, saturating.
// BEHAVIOUR
// - Reset: buffer empty, pointers 0, occupancy_o=0, overflow_o=0, drop_cnt_o=0.
// - Reset outputs: uop_entry_o all-zero (valid=0), in_ready_o=1.
// - Reset asserted mid-operation discards all contents immediately (asynchronous).
// - Push:
//   - Valid entries of uop_entry_i are compacted in ascending port order; invalid ports are holes and are skipped.
//   - Example: only ports 0 and 2 valid -> 2 writes, port 0 first.
//   - npush = popcount of the valid bits; npush=0 is a no-op.
// - in_ready_o = (DEPTH - occupancy) >= NR_COMMIT_PORTS.
//   - Computed from registered occupancy only; a same-cycle pop is NOT credited.
//   - No combinational path from out_ready_i.
// - Overflow:
//   - If npush>0 and in_ready_o=0, the whole group is dropped (never a partial write).
//   - overflow_o sets to 1 next cycle.
//   - drop_cnt_o += npush, saturating at 16'hFFFF.
// - Pop:
//   - uop_entry_o is driven combinationally from the head slot.
//   - Pop occurs when uop_entry_o.valid && out_ready_i; the head pointer advances 1.
// - Latency: an entry pushed at cycle N is visible on uop_entry_o at N+1 at the earliest (buffer was empty).
// - Simultaneous push+pop: occupancy_next = occupancy + npush - pop. Pop of the old head is always legal.
// - Pointer arithmetic:
//   - Wrap modulo DEPTH via natural $clog2(DEPTH)-bit overflow.
//   - Full/empty are decided by occupancy, never by pointer compare.
// - Flush:
//   - flush_i=1 -> next cycle occupancy=0, pointers=0, overflow_o=0, drop_cnt_o=0.
//   - Pushes and pops in the flush cycle are ignored.
//   - flush_i takes priority over push, pop and overflow.
// - Field integrity: entries are stored whole (pc, itype, cause, tval, priv, compressed); no field is modified.
// - No state machine beyond the FIFO counters; ordering guarantee = strict program order across ports and cycles.
// STRUCTURE
// - mure_pkg:
//   - add NR_COMMIT_PORTS and UOP_BUF_DEPTH constants;
//   - reuse uop_entry_s;
//   - add DROP_CNT_LEN=16.
// - Sub-module uop_mp_fifo:
//   - multi-push (up to NR_COMMIT_PORTS), single-pop FIFO with occupancy and flush.
// - Top level holds:
//   - compaction (prefix count of valid bits giving write offsets);
//   - ready/overflow logic;
//   - drop counter.
// TESTING
// - Reset, then idle:
//   - required: uop_entry_o.valid=0, in_ready_o=1, occupancy_o=0 throughout.
// - Single push:
//   - stimulus: port0 pc=0x80000000 itype=0 at N; out_ready_i=1.
//   - required: uop_entry_o.pc=0x80000000 valid at N+1, occupancy_o back to 0 at N+2.
// - Dual commit, ports 0/1 pc=0x100/0x104 every cycle for 6 cycles, out_ready_i=1:
//   - required: output pc sequence 0x100,0x104,... in order.
//   - required: in_ready_o drops when occupancy reaches 7.
// - Hole compaction:
//   - stimulus: port0 invalid, port1 pc=0x200 itype=1 cause=2.
//   - required: single entry out, pc=0x200, itype=1, cause=2 unaltered.
// - Overflow:
//   - stimulus: out_ready_i=0, dual commits until full, then one more group of 2.
//   - required: occupancy_o=8; that group dropped whole; overflow_o=1; drop_cnt_o=2.
// - Flush with simultaneous push:
//   - stimulus: occupancy=5, flush_i=1 together with a valid port0 entry.
//   - required: next cycle occupancy_o=0, overflow_o=0, uop_entry_o.valid=0.

Source files
------------

// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared trace-encoder types and uop buffer constants
package mure_pkg;

    localparam int unsigned XLEN            = 64;
    localparam int unsigned ITYPE_LEN       = 3;
    localparam int unsigned PRIV_LEN        = 2;
    localparam int unsigned NR_COMMIT_PORTS = 2;
    localparam int unsigned UOP_BUF_DEPTH   = 8;
    localparam int unsigned DROP_CNT_LEN    = 16;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [ITYPE_LEN-1:0] itype;
        logic [XLEN-1:0]      cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
        logic                 compressed;
    } uop_entry_s;

endpackage

// File: rtl/uop_serializer_if.sv
// rtl/uop_serializer_if.sv - commit-group input and head-entry output bundle
interface uop_serializer_if #(
    parameter int unsigned NR_PORTS = mure_pkg::NR_COMMIT_PORTS
) ();
    import mure_pkg::*;

    uop_entry_s [NR_PORTS-1:0] uop_entry_i;
    logic                      in_ready_o;
    uop_entry_s                uop_entry_o;
    logic                      out_ready_i;

    modport master (
        output uop_entry_i,
        input  in_ready_o,
        input  uop_entry_o,
        output out_ready_i
    );

    modport slave (
        input  uop_entry_i,
        output in_ready_o,
        output uop_entry_o,
        input  out_ready_i
    );

endinterface

// File: rtl/uop_serializer_mp_fifo.sv
// rtl/uop_serializer_mp_fifo.sv - multi-push single-pop uop FIFO with occupancy and flush
module uop_mp_fifo #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          flush_i,
    input  logic                                          push_i,
    input  logic [$clog2(NR_PORTS+1)-1:0]                 npush_i,
    input  logic [NR_PORTS-1:0]                           wr_valid_i,
    input  logic [NR_PORTS-1:0][$clog2(DEPTH)-1:0]        wr_offset_i,
    input  mure_pkg::uop_entry_s [NR_PORTS-1:0]           wr_data_i,
    input  logic                                          pop_i,
    output mure_pkg::uop_entry_s                          head_o,
    output logic [$clog2(DEPTH+1)-1:0]                    occupancy_o
);
    import mure_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    uop_entry_s                    mem [DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q;
    logic [PTR_W-1:0]              rd_ptr_q;
    logic [OCC_W-1:0]              occ_q;
    logic [NR_PORTS-1:0][PTR_W-1:0] waddr;
    logic                          empty;
    logic                          do_pop;

    assign empty       = (occ_q == '0);
    assign do_pop      = pop_i && !empty;
    assign occupancy_o = occ_q;

    // Pointers wrap by natural overflow; full/empty come from occ_q alone.
    always_comb begin
        waddr = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            waddr[p] = wr_ptr_q + wr_offset_i[p];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(npush_i);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_q + (push_i ? OCC_W'(npush_i) : OCC_W'(0)) - OCC_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (wr_valid_i[p]) begin
                    mem[waddr[p]] <= wr_data_i[p];
                end
            end
        end
    end

    always_comb begin
        head_o = '0;
        if (!empty) begin
            head_o       = mem[rd_ptr_q];
            head_o.valid = 1'b1;
        end
    end

endmodule

// File: rtl/uop_serializer.sv
// rtl/uop_serializer.sv - serializes multi-port commit groups into an in-order single-entry stream
module uop_serializer #(
    parameter int unsigned NR_COMMIT_PORTS = mure_pkg::NR_COMMIT_PORTS,
    parameter int unsigned DEPTH           = mure_pkg::UOP_BUF_DEPTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    uop_serializer_if.slave                      bus,
    input  logic                                 flush_i,
    output logic [$clog2(DEPTH+1)-1:0]           occupancy_o,
    output logic                                 overflow_o,
    output logic [mure_pkg::DROP_CNT_LEN-1:0]    drop_cnt_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(NR_COMMIT_PORTS+1);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);
    localparam int unsigned DCW   = mure_pkg::DROP_CNT_LEN;

    logic [NR_COMMIT_PORTS-1:0]            valid;
    logic [NR_COMMIT_PORTS-1:0][PTR_W-1:0] offset;
    logic [CNT_W-1:0]                      npush;
    logic                                  in_ready;
    logic                                  accept;
    logic                                  drop;
    logic                                  overflow_q;
    logic [DCW-1:0]                        drop_cnt_q;
    logic [DCW:0]                          drop_sum;

    // Each valid port writes at wr_ptr + (number of valid older ports); holes are skipped.
    always_comb begin
        valid  = '0;
        offset = '0;
        npush  = '0;
        for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
            valid[p]  = bus.uop_entry_i[p].valid;
            offset[p] = PTR_W'(npush);
            if (valid[p]) begin
                npush = npush + CNT_W'(1);
            end
        end
    end

    // Ready looks only at registered occupancy so out_ready_i never feeds in_ready_o.
    assign in_ready       = (occupancy_o <= OCC_W'(DEPTH - NR_COMMIT_PORTS));
    assign bus.in_ready_o = in_ready;
    assign accept         = (npush != '0) && in_ready;
    assign drop           = (npush != '0) && !in_ready;
    assign drop_sum       = {1'b0, drop_cnt_q} + (DCW+1)'(npush);

    uop_mp_fifo #(
        .NR_PORTS (NR_COMMIT_PORTS),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (accept),
        .npush_i     (npush),
        .wr_valid_i  (valid),
        .wr_offset_i (offset),
        .wr_data_i   (bus.uop_entry_i),
        .pop_i       (bus.out_ready_i),
        .head_o      (bus.uop_entry_o),
        .occupancy_o (occupancy_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (flush_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= drop_sum[DCW] ? {DCW{1'b1}} : drop_sum[DCW-1:0];
        end
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
